// File: rtl/beta_pipe_ctl_if.sv
// ============================================================================
// beta_pipe_ctl_if : RF-stage event inputs and stage-control outputs of the
//                    Beta pipeline sequencing controller.
// Revision 1.0
// ============================================================================
`default_nettype none

interface beta_pipe_ctl_if;
   logic       stall_a;
   logic       stall_b;
   logic       mem_busy;
   logic       rf_valid;
   logic [4:0] rf_dest;
   logic [1:0] rf_rdy;
   logic       rf_branch_taken;
   logic       irq;

   logic       en_if;
   logic       en_rf;
   logic       en_alu;
   logic       en_mem;
   logic       en_wb;
   logic       squash_if;
   logic       bubble_alu;
   logic       irq_take;
   logic [6:0] aP0;
   logic [6:0] aP1;
   logic [6:0] aP2;

   // Master drives the pipeline events and observes the controls.
   modport master (
      output stall_a, stall_b, mem_busy, rf_valid, rf_dest, rf_rdy,
             rf_branch_taken, irq,
      input  en_if, en_rf, en_alu, en_mem, en_wb, squash_if, bubble_alu,
             irq_take, aP0, aP1, aP2
   );

   modport slave (
      input  stall_a, stall_b, mem_busy, rf_valid, rf_dest, rf_rdy,
             rf_branch_taken, irq,
      output en_if, en_rf, en_alu, en_mem, en_wb, squash_if, bubble_alu,
             irq_take, aP0, aP1, aP2
   );
endinterface

`default_nettype wire

// File: rtl/beta_pipe_ctl.sv
// ============================================================================
// beta_pipe_ctl : stage enables, squash/bubble/trap control and the
//                 ALU/MEM/WB destination-readiness tag pipeline of the Beta.
// Revision 1.0
// ============================================================================
`default_nettype none

module beta_pipe_ctl #(
   parameter int XP_REG   = 30,
   parameter int NULL_REG = 31
) (
   input  logic           clk,
   input  logic           rst_n,
   beta_pipe_ctl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HAZ   = 2'd1,
      ST_MWAIT = 2'd2,
      ST_TRAP  = 2'd3
   } state_t;

   localparam logic [1:0] c_rdy_load   = 2'b00;
   localparam logic [1:0] c_rdy_alu    = 2'b01;
   localparam logic [1:0] c_rdy_early  = 2'b10;
   localparam logic [6:0] c_bubble_tag = {c_rdy_alu, 5'(NULL_REG)};
   localparam logic [6:0] c_xp_tag     = {c_rdy_early, 5'(XP_REG)};

   state_t     state_q, state_d;
   logic [6:0] ap0_q, ap1_q, ap2_q;
   logic [6:0] ap0_d, ap1_d, ap2_d;

   logic w_hz;
   logic w_take;
   logic w_adv_back;
   logic w_adv_front;
   logic w_bubble;
   logic w_squash;

   always_comb begin
      w_hz        = (bus.stall_a | bus.stall_b) & bus.rf_valid;
      w_adv_back  = rst_n & ~bus.mem_busy;
      w_adv_front = w_adv_back & ~w_hz;
      w_bubble    = w_adv_back & w_hz;
      // The trap cycle itself blocks re-acceptance of a still-high irq.
      w_take      = w_adv_front & bus.irq & (state_q != ST_TRAP);
      // A taken branch coinciding with the trap dies with its instruction,
      // but the fetched successor is squashed either way.
      w_squash    = w_adv_front & (w_take | bus.rf_branch_taken);
   end

   always_comb begin
      state_d = ST_RUN;
      if (bus.mem_busy) begin
         state_d = ST_MWAIT;
      end else if (w_hz) begin
         state_d = ST_HAZ;
      end else if (w_take) begin
         state_d = ST_TRAP;
      end
   end

   always_comb begin
      ap0_d = {bus.rf_rdy, bus.rf_dest};
      if (w_take) begin
         ap0_d = c_xp_tag;
      end else if (w_bubble || !bus.rf_valid) begin
         ap0_d = c_bubble_tag;
      end
      ap1_d = ap0_q;
      // Load data is only forwarded from WB, where it counts as ready.
      ap2_d = {(ap1_q[6:5] == c_rdy_load) ? c_rdy_alu : ap1_q[6:5], ap1_q[4:0]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         ap0_q   <= c_bubble_tag;
         ap1_q   <= c_bubble_tag;
         ap2_q   <= c_bubble_tag;
      end else begin
         state_q <= state_d;
         if (w_adv_back) begin
            ap0_q <= ap0_d;
            ap1_q <= ap1_d;
            ap2_q <= ap2_d;
         end
      end
   end

   assign bus.en_if      = w_adv_front;
   assign bus.en_rf      = w_adv_front;
   assign bus.en_alu     = w_adv_back;
   assign bus.en_mem     = w_adv_back;
   assign bus.en_wb      = w_adv_back;
   assign bus.squash_if  = w_squash;
   assign bus.bubble_alu = w_bubble;
   assign bus.irq_take   = w_take;
   assign bus.aP0        = ap0_q;
   assign bus.aP1        = ap1_q;
   assign bus.aP2        = ap2_q;

   a_bubble_vs_trap : assert property (@(posedge clk) !(w_bubble && w_take));
   a_front_enables  : assert property (@(posedge clk) bus.en_if == bus.en_rf);
   a_busy_freezes   : assert property (@(posedge clk)
      bus.mem_busy |-> !(bus.en_if | bus.en_rf | bus.en_alu | bus.en_mem | bus.en_wb));

endmodule

`default_nettype wire

// File: tb/tb_beta_pipe_ctl.sv
// ============================================================================
// tb_beta_pipe_ctl : directed scenarios plus randomized traffic checked
//                    against a queue-based model of the Beta pipeline control.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_beta_pipe_ctl;

   localparam logic [6:0] BUB = 7'h3F;
   localparam logic [6:0] XPT = 7'h5E;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   beta_pipe_ctl_if bus ();

   beta_pipe_ctl #(.XP_REG(30), .NULL_REG(31)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: tags as a 3-deep queue (ALU, MEM, WB) plus a flag
   // remembering that the previous cycle took an interrupt.
   logic [6:0] m_pipe[$];
   bit         m_trap_last;

   always @(posedge clk) begin
      bit         hz, take;
      logic [6:0] entry;
      if (!rst_n) begin
         m_pipe      = '{BUB, BUB, BUB};
         m_trap_last = 1'b0;
      end else begin
         hz   = (bus.stall_a || bus.stall_b) && bus.rf_valid;
         take = !bus.mem_busy && !hz && bus.irq && !m_trap_last;
         if (!bus.mem_busy) begin
            if (take)                       entry = XPT;
            else if (hz || !bus.rf_valid)   entry = BUB;
            else                            entry = {bus.rf_rdy, bus.rf_dest};
            m_pipe.push_front(entry);
            void'(m_pipe.pop_back());
            if (m_pipe[2][6:5] == 2'b00) m_pipe[2][6:5] = 2'b01;
         end
         m_trap_last = take;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.stall_a         = 1'b0;
      bus.stall_b         = 1'b0;
      bus.mem_busy        = 1'b0;
      bus.rf_valid        = 1'b1;
      bus.rf_dest         = 5'd31;
      bus.rf_rdy          = 2'b01;
      bus.rf_branch_taken = 1'b0;
      bus.irq             = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] en;
      rst_n = 1'b0;
      set_idle();
      bus.irq     = 1'b1;
      bus.stall_a = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en = {bus.en_if, bus.en_rf, bus.en_alu, bus.en_mem, bus.en_wb};
         checks++;
         if (en !== 5'h00 || bus.irq_take !== 1'b0 || bus.squash_if !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: en=%h take=%b squash=%b expected all zero",
                     en, bus.irq_take, bus.squash_if);
         end
         checks++;
         if ({bus.aP0, bus.aP1, bus.aP2} !== {BUB, BUB, BUB}) begin
            failures++;
            $display("FAIL reset_tags: got %h %h %h expected 3f 3f 3f",
                     bus.aP0, bus.aP1, bus.aP2);
         end
         step();
      end
      rst_n = 1'b1;
      set_idle();
      @(negedge clk);
      en = {bus.en_if, bus.en_rf, bus.en_alu, bus.en_mem, bus.en_wb};
      checks++;
      if (en !== 5'h1F || bus.irq_take !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: en=%h take=%b expected 1f 0", en, bus.irq_take);
      end
      step();
   endtask

   task automatic test_alu_dep();
      set_idle();
      bus.rf_dest = 5'd3;
      bus.rf_rdy  = 2'b01;
      @(negedge clk);
      checks++;
      if (bus.bubble_alu !== 1'b0 || bus.en_rf !== 1'b1) begin
         failures++;
         $display("FAIL alu_issue: bubble=%b en_rf=%b expected 0 1", bus.bubble_alu, bus.en_rf);
      end
      step();
      bus.rf_dest = 5'd7;
      @(negedge clk);
      checks++;
      if (bus.aP0 !== 7'h23 || bus.bubble_alu !== 1'b0) begin
         failures++;
         $display("FAIL alu_ap0: aP0=%h bubble=%b expected 23 0", bus.aP0, bus.bubble_alu);
      end
      step();
      set_idle();
      @(negedge clk);
      checks++;
      if (bus.aP1 !== 7'h23) begin
         failures++;
         $display("FAIL alu_ap1: aP1=%h expected 23", bus.aP1);
      end
      step();
   endtask

   task automatic test_load_use();
      int  bubbles;
      bit  advanced;
      set_idle();
      bus.rf_dest = 5'd5;
      bus.rf_rdy  = 2'b00;
      step();
      bus.rf_dest = 5'd6;
      bus.rf_rdy  = 2'b01;
      bubbles  = 0;
      advanced = 1'b0;
      for (int i = 0; i < 6 && !advanced; i++) begin
         // Behave like the operand-A bypass unit watching for the load.
         bus.stall_a = (bus.aP0 == 7'h05) || (bus.aP1 == 7'h05);
         @(negedge clk);
         if (bus.stall_a) begin
            bubbles++;
            checks++;
            if (bus.bubble_alu !== 1'b1 || bus.en_rf !== 1'b0) begin
               failures++;
               $display("FAIL load_stall: bubble=%b en_rf=%b expected 1 0",
                        bus.bubble_alu, bus.en_rf);
            end
            step();
         end else begin
            advanced = 1'b1;
            checks++;
            if (bus.aP2 !== 7'h25 || bus.en_rf !== 1'b1) begin
               failures++;
               $display("FAIL load_advance: aP2=%h en_rf=%b expected 25 1", bus.aP2, bus.en_rf);
            end
         end
      end
      checks++;
      if (bubbles != 2) begin
         failures++;
         $display("FAIL load_bubbles: got %0d expected 2", bubbles);
      end
      step();
      set_idle();
   endtask

   task automatic test_mem_freeze();
      logic [4:0] en;
      set_idle();
      bus.rf_rdy = 2'b01; bus.rf_dest = 5'd1; step();
      bus.rf_rdy = 2'b01; bus.rf_dest = 5'd2; step();
      bus.rf_rdy = 2'b10; bus.rf_dest = 5'd4; step();
      bus.rf_rdy = 2'b01; bus.rf_dest = 5'd8;
      bus.stall_b = 1'b1;
      @(negedge clk);
      en = {bus.en_if, bus.en_rf, bus.en_alu, bus.en_mem, bus.en_wb};
      checks++;
      if (en !== 5'h07 || bus.bubble_alu !== 1'b1) begin
         failures++;
         $display("FAIL haz_enter: en=%h bubble=%b expected 07 1", en, bus.bubble_alu);
      end
      step();
      bus.mem_busy        = 1'b1;
      bus.irq             = 1'b1;
      bus.rf_branch_taken = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         en = {bus.en_if, bus.en_rf, bus.en_alu, bus.en_mem, bus.en_wb};
         checks++;
         if (en !== 5'h00 || {bus.squash_if, bus.bubble_alu, bus.irq_take} !== 3'b000) begin
            failures++;
            $display("FAIL freeze_ctl: en=%h ctl=%b%b%b expected 00 000", en,
                     bus.squash_if, bus.bubble_alu, bus.irq_take);
         end
         checks++;
         if ({bus.aP0, bus.aP1, bus.aP2} !== {BUB, 7'h44, 7'h22}) begin
            failures++;
            $display("FAIL freeze_tags: got %h %h %h expected 3f 44 22",
                     bus.aP0, bus.aP1, bus.aP2);
         end
         step();
      end
      bus.mem_busy        = 1'b0;
      bus.irq             = 1'b0;
      bus.rf_branch_taken = 1'b0;
      @(negedge clk);
      en = {bus.en_if, bus.en_rf, bus.en_alu, bus.en_mem, bus.en_wb};
      checks++;
      if (en !== 5'h07 || bus.bubble_alu !== 1'b1) begin
         failures++;
         $display("FAIL haz_resume: en=%h bubble=%b expected 07 1", en, bus.bubble_alu);
      end
      step();
      set_idle();
      @(negedge clk);
      checks++;
      if ({bus.aP0, bus.aP1, bus.aP2} !== {BUB, BUB, 7'h44}) begin
         failures++;
         $display("FAIL haz_tags: got %h %h %h expected 3f 3f 44", bus.aP0, bus.aP1, bus.aP2);
      end
      step();
   endtask

   task automatic test_branch();
      set_idle();
      bus.rf_branch_taken = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.squash_if !== 1'b1) begin
         failures++;
         $display("FAIL branch_squash: got %b expected 1", bus.squash_if);
      end
      step();
      bus.rf_branch_taken = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.squash_if !== 1'b0) begin
         failures++;
         $display("FAIL branch_once: got %b expected 0", bus.squash_if);
      end
      step();
      bus.rf_branch_taken = 1'b1;
      bus.stall_b         = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.squash_if !== 1'b0) begin
            failures++;
            $display("FAIL branch_stalled: got %b expected 0", bus.squash_if);
         end
         step();
      end
      bus.stall_b = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.squash_if !== 1'b1) begin
         failures++;
         $display("FAIL branch_release: got %b expected 1", bus.squash_if);
      end
      step();
      set_idle();
   endtask

   task automatic test_irq();
      set_idle();
      bus.irq             = 1'b1;
      bus.rf_branch_taken = 1'b1;
      bus.rf_dest         = 5'd9;
      @(negedge clk);
      checks++;
      if ({bus.irq_take, bus.squash_if, bus.en_if, bus.en_wb} !== 4'b1111) begin
         failures++;
         $display("FAIL irq_take: take/squash/en_if/en_wb=%b%b%b%b expected 1111",
                  bus.irq_take, bus.squash_if, bus.en_if, bus.en_wb);
      end
      step();
      bus.rf_branch_taken = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.aP0 !== XPT || bus.irq_take !== 1'b0) begin
         failures++;
         $display("FAIL irq_tag: aP0=%h take=%b expected 5e 0", bus.aP0, bus.irq_take);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.irq_take !== 1'b1) begin
         failures++;
         $display("FAIL irq_retake: got %b expected 1", bus.irq_take);
      end
      step();
      set_idle();
      step();
   endtask

   task automatic test_random();
      bit         hz, take, back, front;
      logic [4:0] exp_en, en;
      logic [2:0] exp_ctl, ctl;
      for (int i = 0; i < 400; i++) begin
         rst_n               = ($urandom_range(0, 49) != 0);
         bus.stall_a         = ($urandom_range(0, 5) == 0);
         bus.stall_b         = ($urandom_range(0, 5) == 0);
         bus.mem_busy        = ($urandom_range(0, 5) == 0);
         bus.rf_valid        = ($urandom_range(0, 7) != 0);
         bus.rf_dest         = 5'($urandom);
         bus.rf_rdy          = 2'($urandom);
         bus.rf_branch_taken = ($urandom_range(0, 3) == 0);
         bus.irq             = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         hz     = (bus.stall_a || bus.stall_b) && bus.rf_valid;
         back   = rst_n && !bus.mem_busy;
         front  = back && !hz;
         take   = front && bus.irq && !m_trap_last;
         exp_en = {front, front, back, back, back};
         exp_ctl = {front && (take || bus.rf_branch_taken), back && hz, take};
         en  = {bus.en_if, bus.en_rf, bus.en_alu, bus.en_mem, bus.en_wb};
         ctl = {bus.squash_if, bus.bubble_alu, bus.irq_take};
         checks++;
         if (en !== exp_en) begin
            failures++;
            $display("FAIL rand_en[%0d]: got %b expected %b", i, en, exp_en);
         end
         checks++;
         if (ctl !== exp_ctl) begin
            failures++;
            $display("FAIL rand_ctl[%0d]: squash/bubble/take got %b expected %b", i, ctl, exp_ctl);
         end
         checks++;
         if ({bus.aP0, bus.aP1, bus.aP2} !== {m_pipe[0], m_pipe[1], m_pipe[2]}) begin
            failures++;
            $display("FAIL rand_tags[%0d]: got %h %h %h expected %h %h %h", i,
                     bus.aP0, bus.aP1, bus.aP2, m_pipe[0], m_pipe[1], m_pipe[2]);
         end
         step();
      end
      rst_n = 1'b1;
      set_idle();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_alu_dep();
      test_load_use();
      test_mem_freeze();
      test_branch();
      test_irq();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
